serial_nibble_loader: RTL and testbench



---
 rtl/serial_loader_pkg.sv | 25 ++
 rtl/serial_nibble_shifter.sv | 61 ++++++
 rtl/serial_nibble_loader.sv | 139 +++++++++++++
 tb/tb_serial_nibble_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_loader_pkg.sv
// -----------------------------------------------------------------------------
// serial_loader_pkg
// Shared definitions for the serial nibble loader:
//   - state_t    : receiver FSM states (PARITY is only reached when the
//                  SERIAL_PARITY_CHECK_EN macro is defined)
//   - STATE_W    : width of the state encoding
//   - SIN_IDLE   : idle / stop level of the serial line
//   - START_BIT  : level of the start bit
// -----------------------------------------------------------------------------
package serial_loader_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        LOAD   = 3'd4
    } state_t;

    localparam logic SIN_IDLE  = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_nibble_shifter.sv
// -----------------------------------------------------------------------------
// serial_nibble_shifter
// Parameterised shift register plus bit counter used by serial_nibble_loader
// to assemble one data word from the serial line.
//
// Parameters:
//   DATA_W     number of bits per word
//   LSB_FIRST  1 = first shifted bit ends in word[0],
//              0 = first shifted bit ends in word[DATA_W-1]
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   clr       in   clears shift register and bit counter
//   shift_en  in   shift bit_in into the register and count it
//   bit_in    in   serial bit to shift in
//   word      out  current shift register contents
//   done      out  high in the cycle whose shift completes the word
// -----------------------------------------------------------------------------
module serial_nibble_shifter
    import serial_loader_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] word,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_count;

    // Shift register and counter. For LSB-first the new bit enters at the top
    // and walks down, so after DATA_W shifts the first bit sits in bit 0; for
    // MSB-first it enters at the bottom and walks up.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (shift_en) begin
            if (LSB_FIRST != 0) begin
                r_shift <= {bit_in, r_shift[DATA_W-1:1]};
            end else begin
                r_shift <= {r_shift[DATA_W-2:0], bit_in};
            end
            r_count <= r_count + 1'b1;
        end
    end

    // Flag the shift that brings the count to DATA_W so the FSM can leave the
    // data phase on the same edge; the counter therefore stops at DATA_W.
    assign done = shift_en && (r_count == CNT_W'(DATA_W - 1));
    assign word = r_shift;

endmodule

// File: rtl/serial_nibble_loader.sv
// -----------------------------------------------------------------------------
// serial_nibble_loader
// Receives one framed serial word (start bit, DATA_W data bits, [even parity],
// stop bit) sampled on sample_en. A good frame is presented on d and announced
// by a one-cycle active-low load_n pulse; a bad frame pulses frame_err.
//
// Optional feature: define SERIAL_PARITY_CHECK_EN to insert an even-parity bit
// between the data bits and the stop bit.
//
// Parameters:
//   DATA_W     data bits per frame / width of d
//   LSB_FIRST  1 = first data bit lands in d[0], 0 = in d[DATA_W-1]
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   sin        in   serial line, idles high
//   sample_en  in   one-cycle bit-sample strobe
//   d          out  last good word
//   load_n     out  active-low load strobe, one cycle per good frame
//   busy       out  high while a frame is in progress
//   frame_err  out  one-cycle pulse on a bad stop (or parity) bit
// -----------------------------------------------------------------------------
module serial_nibble_loader
    import serial_loader_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    input  logic              sample_en,
    output logic [DATA_W-1:0] d,
    output logic              load_n,
    output logic              busy,
    output logic              frame_err
);

    state_t            r_state;
    logic [DATA_W-1:0] r_d;
    logic              r_load_n;
    logic              r_busy;
    logic              r_frame_err;

    logic              w_clr;
    logic              w_shift;
    logic [DATA_W-1:0] w_word;
    logic              w_done;

    // A start bit restarts word assembly; data bits shift only in DATA.
    assign w_clr   = (r_state == IDLE) && sample_en && (sin == START_BIT);
    assign w_shift = (r_state == DATA) && sample_en;

    serial_nibble_shifter #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_clr),
        .shift_en (w_shift),
        .bit_in   (sin),
        .word     (w_word),
        .done     (w_done)
    );

    // Receiver FSM with registered outputs. load_n and frame_err default to
    // their inactive levels every cycle so each assertion is a single pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_d         <= '0;
            r_load_n    <= 1'b1;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_load_n    <= 1'b1;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sample_en && (sin == START_BIT)) begin
                        r_state <= DATA;
                        r_busy  <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_done) begin
`ifdef SERIAL_PARITY_CHECK_EN
                        r_state <= PARITY;
`else
                        r_state <= STOP;
`endif
                    end
                end
`ifdef SERIAL_PARITY_CHECK_EN
                PARITY: begin
                    // Even parity: data bits and parity bit must XOR to 0.
                    if (sample_en) begin
                        if (((^w_word) ^ sin) == 1'b0) begin
                            r_state <= STOP;
                        end else begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_frame_err <= 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (sample_en) begin
                        if (sin == SIN_IDLE) begin
                            r_state  <= LOAD;
                            r_d      <= w_word;
                            r_load_n <= 1'b0;
                        end else begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign d         = r_d;
    assign load_n    = r_load_n;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_nibble_loader.sv
// -----------------------------------------------------------------------------
// tb_serial_nibble_loader
// Drives two serial_nibble_loader instances (LSB_FIRST=1 and LSB_FIRST=0) from
// the same serial line. Each frame sent pushes the expected outcome (good word
// or frame error, plus the cycle it must appear in) into a per-instance queue;
// a monitor on the falling edge pops and compares whenever an instance shows
// load_n=0 or frame_err=1. Honours SERIAL_PARITY_CHECK_EN like the design.
// -----------------------------------------------------------------------------
module tb_serial_nibble_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       sin;
    logic       sample_en;

    logic [3:0] dLsb, dMsb;
    logic       loadNLsb, loadNMsb;
    logic       busyLsb, busyMsb;
    logic       ferrLsb, ferrMsb;

    typedef struct {
        bit         isErr;
        logic [3:0] word;
        int         cyc;
    } evt_t;

    evt_t       expQ[2][$];
    logic [3:0] curD[2];
    bit         busyCheckNext[2];
    int         checks = 0;
    int         errors = 0;
    int         cycleCount = 0;
    int         lastSampleCycle = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    serial_nibble_loader #(.DATA_W(4), .LSB_FIRST(1)) u_dutLsb (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sample_en (sample_en),
        .d         (dLsb),
        .load_n    (loadNLsb),
        .busy      (busyLsb),
        .frame_err (ferrLsb)
    );

    serial_nibble_loader #(.DATA_W(4), .LSB_FIRST(0)) u_dutMsb (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sample_en (sample_en),
        .d         (dMsb),
        .load_n    (loadNMsb),
        .busy      (busyMsb),
        .frame_err (ferrMsb)
    );

    // One comparison: counts it, reports it on mismatch.
    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)",
                     name, k, actual, expected, cycleCount);
        end
    endtask

    // Reference word: bit i of the arrival order is worth 2^i (LSB first)
    // or 2^(3-i) (MSB first).
    function automatic logic [3:0] modelWord(input logic [3:0] bits, input bit lsbFirst);
        int w = 0;
        for (int i = 0; i < 4; i++) begin
            if (bits[i]) w += lsbFirst ? (1 << i) : (1 << (3 - i));
        end
        return w[3:0];
    endfunction

    // Queue the expected outcome for both instances, due in the cycle right
    // after the edge that sampled the last bit of the frame.
    task automatic pushExpect(input logic [3:0] bits, input bit isErr);
        evt_t e;
        for (int k = 0; k < 2; k++) begin
            e.isErr = isErr;
            e.word  = modelWord(bits, (k == 0));
            e.cyc   = lastSampleCycle;
            expQ[k].push_back(e);
        end
    endtask

    // Present one bit with a single-cycle sample_en, optionally after a few
    // idle cycles; pulses are always at least two clocks apart.
    task automatic sampleBit(input logic b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #1;
        sample_en = 1'b1;
        sin       = b;
        @(posedge clk);
        #1;
        lastSampleCycle = cycleCount;
        sample_en = 1'b0;
        sin       = 1'($urandom);
    endtask

    // Send one frame; bits[i] is the i-th data bit on the wire.
    task automatic applyStimulus(input logic [3:0] bits, input logic stopBit, input bit parFlip);
        sampleBit(1'b0);
        for (int i = 0; i < 4; i++) sampleBit(bits[i]);
`ifdef SERIAL_PARITY_CHECK_EN
        sampleBit((^bits) ^ parFlip);
        if (parFlip) begin
            pushExpect(bits, 1'b1);
            return;
        end
`else
        if (parFlip) begin
            stopBit = stopBit;
        end
`endif
        sampleBit(stopBit);
        pushExpect(bits, !stopBit);
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        sample_en = 1'b0;
        sin       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        curD[0] = 4'h0;
        curD[1] = 4'h0;
        busyCheckNext[0] = 1'b0;
        busyCheckNext[1] = 1'b0;
        reset = 1'b0;
    endtask

    // Monitor: any load or frame error must match the head of the queue;
    // an expected event whose cycle has passed is reported as missing.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                logic       lN, fe, bz;
                logic [3:0] dd;
                evt_t       e;
                lN = (k == 0) ? loadNLsb : loadNMsb;
                fe = (k == 0) ? ferrLsb  : ferrMsb;
                bz = (k == 0) ? busyLsb  : busyMsb;
                dd = (k == 0) ? dLsb     : dMsb;
                if (busyCheckNext[k]) begin
                    checkOutput("busyAfterLoad", k, 32'(bz), 32'd0);
                    checkOutput("loadNAfterLoad", k, 32'(lN), 32'd1);
                    busyCheckNext[k] = 1'b0;
                end
                while (expQ[k].size() > 0 && expQ[k][0].cyc < cycleCount) begin
                    e = expQ[k].pop_front();
                    checks++;
                    errors++;
                    $display("[TB] FAIL missedEvent dut%0d: nothing seen, expected %s of %0h due cycle %0d",
                             k, e.isErr ? "frame_err" : "load", e.word, e.cyc);
                end
                if (!lN || fe) begin
                    if (expQ[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpectedEvent dut%0d: load_n=%0b frame_err=%0b, expected none (cycle %0d)",
                                 k, lN, fe, cycleCount);
                    end else begin
                        e = expQ[k].pop_front();
                        checkOutput("frameErr", k, 32'(fe), 32'(e.isErr));
                        checkOutput("loadN", k, 32'(lN), 32'(e.isErr));
                        checkOutput("eventCycle", k, 32'(cycleCount), 32'(e.cyc));
                        if (!e.isErr) begin
                            checkOutput("dOnLoad", k, 32'(dd), 32'(e.word));
                            checkOutput("busyInLoad", k, 32'(bz), 32'd1);
                            curD[k] = e.word;
                            busyCheckNext[k] = 1'b1;
                        end else begin
                            checkOutput("dHeldOnErr", k, 32'(dd), 32'(curD[k]));
                            checkOutput("busyOnErr", k, 32'(bz), 32'd0);
                        end
                    end
                end
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Main sequence: reset, idle line, directed frames, then random frames.
    initial begin
        logic [3:0] bits;
        logic       stopBit;
        bit         flip;

        curD[0] = 4'h0;
        curD[1] = 4'h0;
        busyCheckNext[0] = 1'b0;
        busyCheckNext[1] = 1'b0;
        reset     = 1'b1;
        sin       = 1'b1;
        sample_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetD", 0, 32'(dLsb), 32'd0);
        checkOutput("resetD", 1, 32'(dMsb), 32'd0);
        checkOutput("resetLoadN", 0, 32'(loadNLsb), 32'd1);
        checkOutput("resetBusy", 0, 32'(busyLsb), 32'd0);
        checkOutput("resetFrameErr", 0, 32'(ferrLsb), 32'd0);
        reset = 1'b0;

        // Idle line with periodic strobes must never start a frame.
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            sample_en = (c % 4 == 0);
            sin       = 1'b1;
            @(negedge clk);
            checkOutput("idleOutputs", 0, {dLsb, loadNLsb, busyLsb, ferrLsb}, {4'h0, 3'b100});
            checkOutput("idleOutputs", 1, {dMsb, loadNMsb, busyMsb, ferrMsb}, {4'h0, 3'b100});
        end
        @(posedge clk);
        #1;
        sample_en = 1'b0;

        // Wire order 1,0,1,1: LSB-first gives 1101, MSB-first gives 1011.
        applyStimulus(4'b1101, 1'b1, 1'b0);
        // Bad stop bit after 1,1,1,1: error, d keeps previous word.
        applyStimulus(4'b1111, 1'b0, 1'b0);

        // Reset after the second data bit discards the partial frame.
        sampleBit(1'b0);
        sampleBit(1'b1);
        sampleBit(1'b1);
        applyReset();
        @(negedge clk);
        checkOutput("dAfterMidReset", 0, 32'(dLsb), 32'd0);
        checkOutput("dAfterMidReset", 1, 32'(dMsb), 32'd0);
        checkOutput("busyAfterMidReset", 0, 32'(busyLsb), 32'd0);
        applyStimulus(4'b0110, 1'b1, 1'b0);

`ifdef SERIAL_PARITY_CHECK_EN
        applyStimulus(4'b1101, 1'b1, 1'b0);
        applyStimulus(4'b1101, 1'b1, 1'b1);
`endif

        for (int n = 0; n < 30; n++) begin
            bits    = 4'($urandom);
            stopBit = ($urandom_range(0, 3) != 0);
`ifdef SERIAL_PARITY_CHECK_EN
            flip = ($urandom_range(0, 3) == 0);
`else
            flip = 1'b0;
`endif
            applyStimulus(bits, stopBit, flip);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("pendingEvents", 0, 32'(expQ[0].size()), 32'd0);
        checkOutput("pendingEvents", 1, 32'(expQ[1].size()), 32'd0);
        checkOutput("finalD", 0, 32'(dLsb), 32'(curD[0]));
        checkOutput("finalD", 1, 32'(dMsb), 32'(curD[1]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
